// File: rtl/tap_shift_pkg.sv
// Shared defaults and state encoding for the tapped shift-line controller.
// Imported by the controller and its delay-line sub-module.
package tap_shift_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int DEPTH_DEF    = 64;
  localparam int TAP_STEP_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  function automatic int ntap(input int depth, input int step);
    return depth / step;
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Data/valid shift chain with stage-0 load and gated tap extraction.
// Data stages carry no reset; the valid chain masks stale content.
module tap_delay_line
  import tap_shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TAP_STEP = TAP_STEP_DEF,
  localparam int NTAP    = ntap(DEPTH, TAP_STEP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic                  load_valid,
  input  logic [WIDTH-1:0]      load_data,
  output logic [NTAP-1:0]       tap_valid,
  output logic [NTAP*WIDTH-1:0] tap_data,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (shift) begin
      vld_q <= {vld_q[DEPTH-2:0], load_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      dat_q[0] <= load_data;
      for (int i = 1; i < DEPTH; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_comb begin
    tap_valid = '0;
    tap_data  = '0;
    for (int k = 0; k < NTAP; k++) begin
      tap_valid[k] = vld_q[(k+1)*TAP_STEP-1];
      if (vld_q[(k+1)*TAP_STEP-1]) begin
        tap_data[k*WIDTH +: WIDTH] = dat_q[(k+1)*TAP_STEP-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/tap_shift_ctrl.sv
// Handshake, occupancy counter and IDLE/RUN/FLUSH control
// around a tapped delay line.
module tap_shift_ctrl
  import tap_shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TAP_STEP = TAP_STEP_DEF,
  localparam int NTAP    = ntap(DEPTH, TAP_STEP),
  localparam int OW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [NTAP-1:0]       tap_valid,
  output logic [NTAP*WIDTH-1:0] tap_data,
  output logic [OW-1:0]         occupancy,
  output logic                  busy
);

  localparam logic [OW-1:0] ONE = OW'(1);

  state_t        state_q;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_nxt;
  logic          stall;
  logic          accept;
  logic          shift;
  logic          consume;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = (state_q != FLUSH) & ~stall;
  assign accept   = in_valid & in_ready;
  assign shift    = ~stall & (accept | (state_q == FLUSH));
  assign consume  = shift & out_valid;

  always_comb begin
    occ_nxt = occ_q;
    if (accept & ~consume) begin
      occ_nxt = occ_q + ONE;
    end else if (consume & ~accept) begin
      occ_nxt = occ_q - ONE;
    end
  end

  // A flush in RUN wins over the drain-to-IDLE check; FLUSH then exits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
    end else begin
      occ_q <= occ_nxt;
      unique case (state_q)
        IDLE:
          if (accept) state_q <= RUN;
        RUN:
          if (flush) state_q <= FLUSH;
          else if (occ_nxt == '0) state_q <= IDLE;
        FLUSH:
          if (occ_nxt == '0) state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

  assign occupancy = occ_q;
  assign busy      = (state_q != IDLE);

  tap_delay_line #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .TAP_STEP (TAP_STEP)
  ) u_line (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift),
    .load_valid (accept),
    .load_data  (in_data),
    .tap_valid  (tap_valid),
    .tap_data   (tap_data),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

endmodule

// File: tb/tb_tap_shift_ctrl.sv
// Directed bench for tap_shift_ctrl at default parameters.
// Expected values are hand-derived from the shift/occupancy rules.
module tb_tap_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        out_ready;
  logic [3:0]  tap_valid;
  logic [15:0] tap_data;
  logic [6:0]  occupancy;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  tap_shift_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .occupancy (occupancy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i % 16);
      step();
    end
    in_valid = 1'b0;
  endtask

  int acc;
  int seen;
  int shifts;
  int exp0;
  int exp1;

  initial begin
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tap_valid", tap_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_tap_data", tap_data, 0);

    // continuous fill
    for (int n = 1; n <= 64; n++) begin
      in_valid = 1'b1;
      in_data  = 4'((n - 1) % 16);
      step();
      if (n == 15) chk("fill_tap0_early", tap_valid[0], 0);
      if (n == 16) begin
        chk("fill_tap0_on", tap_valid[0], 1);
        chk("fill_tap0_data", tap_data[3:0], 0);
      end
      if (n == 63) chk("fill_out_early", out_valid, 0);
      if (n == 64) begin
        chk("fill_out_on", out_valid, 1);
        chk("fill_out_data", out_data, 0);
        chk("fill_occ", occupancy, 64);
      end
    end
    in_valid = 1'b0;

    // full stall
    do_reset();
    out_ready = 1'b0;
    push_n(64);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_occ", occupancy, 64);
    chk("stall_tap_valid", tap_valid, 4'hf);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 4'(c + 5);
      step();
      chk("stall_hold_occ", occupancy, 64);
      chk("stall_hold_out", out_data, 0);
    end
    out_ready = 1'b1;
    for (int i = 64; i < 67; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i % 16);
      step();
      chk("unstall_occ", occupancy, 64);
      chk("unstall_out", out_data, 64'((i - 63) % 16));
    end
    in_valid = 1'b0;

    // flush drains 20 samples in order
    do_reset();
    push_n(20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_busy", busy, 1);
    chk("flush_occ", occupancy, 20);
    seen   = 0;
    shifts = 0;
    while (shifts < 200) begin
      step();
      shifts++;
      if (!busy) break;
      if (out_valid) begin
        chk("flush_order", out_data, 64'(seen % 16));
        seen++;
      end
    end
    chk("flush_shifts", shifts, 64);
    chk("flush_seen", seen, 20);
    chk("flush_end_occ", occupancy, 0);

    // gapped input
    do_reset();
    acc = 0;
    for (int c = 0; c < 100 && acc < 40; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = 4'((acc * 3 + 1) % 16);
      step();
      if (in_valid) acc++;
      chk("gap_occ", occupancy, 64'(acc));
      chk("gap_tap_valid", tap_valid,
          {2'b00, acc >= 32, acc >= 16});
      if (acc >= 16) begin
        exp0 = ((acc - 16) * 3 + 1) % 16;
        chk("gap_tap0", tap_data[3:0], 64'(exp0));
      end
      if (acc >= 32) begin
        exp1 = ((acc - 32) * 3 + 1) % 16;
        chk("gap_tap1", tap_data[7:4], 64'(exp1));
      end
    end
    in_valid = 1'b0;
    chk("gap_total", acc, 40);

    // reset while flushing
    do_reset();
    push_n(30);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    chk("mf_busy", busy, 1);
    chk("mf_occ", occupancy, 30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mf_rst_occ", occupancy, 0);
    chk("mf_rst_busy", busy, 0);
    chk("mf_rst_out", out_valid, 0);
    chk("mf_rst_tap", tap_valid, 0);
    chk("mf_rst_ready", in_ready, 1);

    // flush in IDLE, flush+accept, repeated flush
    do_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idle_fl_busy", busy, 0);
    chk("idle_fl_occ", occupancy, 0);
    chk("idle_fl_out", out_valid, 0);
    push_n(5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h9;
    step();
    in_valid = 1'b0;
    chk("fl_acc_occ", occupancy, 6);
    chk("fl_acc_busy", busy, 1);
    chk("fl_acc_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("refl_occ", occupancy, 6);
    chk("refl_busy", busy, 1);
    chk("refl_out", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
